// File: rtl/fos_chan_sched.sv
// fos_chan_sched: runs NCH first-order IIR channels, y[n] = x[n-1] - a1*y[n-1],
// on one shared external multiplier, serving pending samples round-robin.
// Ports:
//   clk, reset (async active-low)
//   in_valid/in_data/in_ready : per-channel sample inputs, one-deep buffer each
//   cfg_we/cfg_clr/cfg_ch/cfg_a1 : coefficient write and delay-state clear
//   mult_x/mult_a/mult_p : shared multiplier operands and its combinational product
//   out_valid/out_ch/out_data/out_ready : tagged result stream
//   busy : sequencer active or any sample buffered
module fos_chan_sched #(
    parameter int NCH = 4,
    parameter int W   = 32,
    parameter int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    input  logic             cfg_we,
    input  logic             cfg_clr,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [W-1:0]     cfg_a1,
    output logic [W-1:0]     mult_x,
    output logic [W-1:0]     mult_a,
    input  logic [W-1:0]     mult_p,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, UPD, OUT} state_t;

    state_t         state;
    logic [W-1:0]   a1   [NCH];
    logic [W-1:0]   xd   [NCH];
    logic [W-1:0]   yd   [NCH];
    logic [W-1:0]   hold [NCH];
    logic [NCH-1:0] pend;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  g;
    logic [W-1:0]   prod_r;

    logic [CW-1:0]  gnt;
    logic           gnt_ok;
    logic [CW-1:0]  idx;
    logic [W-1:0]   y;

    // Search starts one past the last served channel so every
    // pending channel is reached within NCH grants.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = CW'((int'(rr_ptr) + i) % NCH);
            if (!gnt_ok && pend[idx]) begin
                gnt    = idx;
                gnt_ok = 1'b1;
            end
        end
    end

    assign y        = xd[g] - prod_r;
    assign mult_x   = (state == MUL) ? yd[g] : '0;
    assign mult_a   = (state == MUL) ? a1[g] : '0;
    assign in_ready = reset ? ~pend : '0;
    assign busy     = (state != IDLE) || (|pend);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= '0;
            rr_ptr    <= CW'(NCH - 1);
            g         <= '0;
            prod_r    <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int c = 0; c < NCH; c++) begin
                a1[c]   <= '0;
                xd[c]   <= '0;
                yd[c]   <= '0;
                hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (in_valid[c] && !pend[c]) begin
                    hold[c] <= in_data[c*W +: W];
                    pend[c] <= 1'b1;
                end
                if (cfg_we && cfg_ch == CW'(c)) begin
                    a1[c] <= cfg_a1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        g     <= gnt;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod_r <= mult_p;
                    state  <= UPD;
                end
                UPD: begin
                    xd[g]     <= hold[g];
                    yd[g]     <= y;
                    pend[g]   <= 1'b0;
                    rr_ptr    <= g;
                    out_data  <= y;
                    out_ch    <= g;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
            // Placed after the UPD writes so a clear on the same edge wins.
            for (int c = 0; c < NCH; c++) begin
                if (cfg_clr && cfg_ch == CW'(c)) begin
                    xd[c] <= '0;
                    yd[c] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fos_chan_sched.sv
// tb_fos_chan_sched: directed tests for fos_chan_sched with a signed
// multiplier model; inputs driven and outputs sampled on the falling edge.
module tb_fos_chan_sched;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NCH-1:0]   in_valid = '0;
    logic [NCH*W-1:0] in_data = '0;
    logic [NCH-1:0]   in_ready;
    logic             cfg_we = 1'b0;
    logic             cfg_clr = 1'b0;
    logic [CW-1:0]    cfg_ch = '0;
    logic [W-1:0]     cfg_a1 = '0;
    logic [W-1:0]     mult_x;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_p;
    logic             out_valid;
    logic [CW-1:0]    out_ch;
    logic [W-1:0]     out_data;
    logic             out_ready = 1'b1;
    logic             busy;

    logic signed [2*W-1:0] prod_full;
    assign prod_full = $signed(mult_x) * $signed(mult_a);
    assign mult_p    = prod_full[W-1:0];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fos_chan_sched #(.NCH(NCH), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_ch(cfg_ch), .cfg_a1(cfg_a1),
        .mult_x(mult_x), .mult_a(mult_a), .mult_p(mult_p),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = '0;
        cfg_we    = 1'b0;
        cfg_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_a1(input int ch, input logic [W-1:0] v);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_ch = CW'(ch);
        cfg_a1 = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns at the falling edge just after the accepting edge.
    task automatic send(input int ch, input logic [W-1:0] v);
        @(negedge clk);
        in_data[ch*W +: W] = v;
        in_valid[ch] = 1'b1;
        @(negedge clk);
        in_valid[ch] = 1'b0;
    endtask

    // n = falling edges waited until out_valid; consumes the result.
    task automatic get_result(output logic [CW-1:0] ch,
                              output logic [W-1:0] d,
                              output int n, output bit ok);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        ch = out_ch;
        d  = out_data;
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = '1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0
            || mult_x !== '0) begin
            bad++;
            $display("FAIL reset_hold: ov=%b rdy=%b busy=%b mx=%h, want 0 0000 0 0",
                     out_valid, in_ready, busy, mult_x);
        end
        in_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b1111 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b busy=%b ov=%b, want 1111 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_in_out();
        int n;
        do_reset();
        out_ready = 1'b0;
        send(0, 32'd5);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_out_reach: ov=%b, want 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_async: ov=%b busy=%b rdy=%b, want 0 0 0000",
                     out_valid, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_impulse();
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        int            n;
        bit            ok;
        logic [W-1:0]  xs [3];
        logic [W-1:0]  ys [3];
        xs = '{32'd5, 32'd0, 32'd0};
        ys = '{32'd0, 32'd5, 32'hFFFF_FFF6};
        do_reset();
        set_a1(0, 32'd2);
        for (int i = 0; i < 3; i++) begin
            send(0, xs[i]);
            get_result(ch, d, n, ok);
            total++;
            if (!ok || ch !== 2'd0 || d !== ys[i] || n != 3) begin
                bad++;
                $display("FAIL impulse%0d: ok=%0b ch=%0d y=%h lat=%0d, want ch=0 y=%h lat=3",
                         i, ok, ch, d, n, ys[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        int            n;
        bit            ok;
        logic [CW-1:0] alt [4];
        alt = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        @(negedge clk);
        in_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        in_valid = 4'b1111;
        @(negedge clk);
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            get_result(ch, d, n, ok);
            total++;
            if (!ok || ch !== CW'(i) || n != 3) begin
                bad++;
                $display("FAIL rr_all%0d: ok=%0b ch=%0d gap=%0d, want ch=%0d gap=3",
                         i, ok, ch, n, i);
            end
        end
        do_reset();
        @(negedge clk);
        in_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            get_result(ch, d, n, ok);
            total++;
            if (!ok || ch !== alt[i]) begin
                bad++;
                $display("FAIL rr_alt%0d: ok=%0b ch=%0d, want ch=%0d",
                         i, ok, ch, alt[i]);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        int            n;
        bit            ok;
        do_reset();
        send(0, 32'd7);
        get_result(ch, d, n, ok);
        out_ready = 1'b0;
        send(0, 32'd9);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd7) begin
            bad++;
            $display("FAIL bp_first: ov=%b y=%h, want 1 00000007",
                     out_valid, out_data);
        end
        in_data[1*W +: W] = 32'd11;
        in_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd7 || out_ch !== 2'd0
                || mult_x !== '0 || mult_a !== '0 || in_ready[1] !== 1'b0
                || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b y=%h ch=%0d mx=%h ma=%h rdy1=%b busy=%b",
                         k, out_valid, out_data, out_ch, mult_x, mult_a,
                         in_ready[1], busy);
            end
        end
        in_valid[1] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || ch !== 2'd1 || d !== 32'd0) begin
            bad++;
            $display("FAIL bp_next: ok=%0b ch=%0d y=%h, want ch=1 y=0",
                     ok, ch, d);
        end
    endtask

    task automatic test_cfg_collision();
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        int            n;
        bit            ok;
        do_reset();
        set_a1(0, 32'd2);
        send(0, 32'd5);
        get_result(ch, d, n, ok);
        send(0, 32'd0);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'd5) begin
            bad++;
            $display("FAIL col_prep: ok=%0b y=%h, want 00000005", ok, d);
        end
        send(0, 32'd0);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_a1 = 32'd3;
        @(negedge clk);
        cfg_we = 1'b0;
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'hFFFF_FFF6) begin
            bad++;
            $display("FAIL col_we_old: ok=%0b y=%h, want fffffff6", ok, d);
        end
        send(0, 32'd0);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'd30) begin
            bad++;
            $display("FAIL col_we_new: ok=%0b y=%h, want 0000001e", ok, d);
        end
        send(0, 32'd4);
        @(negedge clk);
        @(negedge clk);
        cfg_clr = 1'b1;
        cfg_ch  = 2'd0;
        @(negedge clk);
        cfg_clr = 1'b0;
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'hFFFF_FFA6) begin
            bad++;
            $display("FAIL col_clr_y: ok=%0b y=%h, want ffffffa6", ok, d);
        end
        send(0, 32'd6);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'd0) begin
            bad++;
            $display("FAIL col_clr_next: ok=%0b y=%h, want 00000000", ok, d);
        end
        send(0, 32'd0);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'd6) begin
            bad++;
            $display("FAIL col_clr_after: ok=%0b y=%h, want 00000006", ok, d);
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        int            n;
        bit            ok;
        do_reset();
        set_a1(0, 32'd1);
        send(0, 32'd1);
        get_result(ch, d, n, ok);
        send(0, 32'h8000_0000);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'd1) begin
            bad++;
            $display("FAIL wrap_prep: ok=%0b y=%h, want 00000001", ok, d);
        end
        send(0, 32'd0);
        get_result(ch, d, n, ok);
        total++;
        if (!ok || d !== 32'h7FFF_FFFF) begin
            bad++;
            $display("FAIL wrap: ok=%0b y=%h, want 7fffffff", ok, d);
        end
    endtask

    initial begin
        test_reset();
        test_reset_in_out();
        test_impulse();
        test_round_robin();
        test_backpressure();
        test_cfg_collision();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fos_chan_sched.md
Name: fos_chan_sched

Overview:
- Time-multiplexed scheduler that runs NCH independent first-order IIR channels on one shared fixed-point multiplier (external rad4_fixp instance).
- Recurrence per channel: y[n] = x[n-1] - a1*y[n-1].
- Holds per-channel coefficient and delay state, arbitrates pending samples round-robin, and sequences operands to the multiplier.
- Returns results on a valid/ready output tagged with channel number.

Parameters:
- NCH, 4, number of channels (2..16)
- W, 32, sample/coefficient/product width
- CW, $clog2(NCH), channel index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NCH  per-channel sample valid
- in_data  in  NCH*W  per-channel sample; channel c occupies bits [c*W +: W]
- in_ready  out  NCH  per-channel accept
- cfg_we  in  1  write a1 of channel cfg_ch
- cfg_clr  in  1  clear delay state (xd, yd) of channel cfg_ch
- cfg_ch  in  CW  config target channel
- cfg_a1  in  W  coefficient value
- mult_x  out  W  multiplier operand (delayed output)
- mult_a  out  W  multiplier operand (coefficient)
- mult_p  in  W  multiplier product; combinational from mult_x/mult_a
- out_valid  out  1  result valid
- out_ch  out  CW  channel of result
- out_data  out  W  y sample
- out_ready  in  1  downstream accept
- busy  out  1  high when state != IDLE or any pend bit is set

Behaviour:
- Per-channel registers:
  - a1[c]: coefficient.
  - xd[c]: previous input.
  - yd[c]: previous output.
  - hold[c]: buffered sample.
  - pend[c]: buffer occupied.
- in_ready[c] = !pend[c] while reset is deasserted; 0 while reset is asserted.
- Accept on in_valid[c] & in_ready[c]: hold[c] <= in_data slice, pend[c] <= 1.
- FSM states: IDLE, MUL, UPD, OUT.
  - IDLE: if any pend, grant g = first set pend at or after rr_ptr+1 (mod NCH); latch g; go to MUL. Otherwise stay.
  - MUL: mult_x = yd[g], mult_a = a1[g]; prod_r <= mult_p; go to UPD.
  - UPD: y = xd[g] - prod_r, modulo 2^W (two's-complement wrap, no saturation).
    - xd[g] <= hold[g]; yd[g] <= y; pend[g] <= 0; rr_ptr <= g.
    - out_data <= y; out_ch <= g; out_valid <= 1; go to OUT.
  - OUT: hold out_valid, out_data and out_ch stable until out_ready. On out_valid & out_ready: out_valid <= 0, go to IDLE.
- Operand default: mult_x = mult_a = 0 outside MUL.
- Latency: accept edge E0 -> out_valid high after edge E3.
- Throughput: one sample per 4 cycles with out_ready = 1.
- pend[g] clears at UPD, so channel g may accept a new sample while its result waits in OUT. Other channels keep accepting at all times.
- Config write:
  - cfg_we updates a1[cfg_ch] at the clock edge.
  - A write coinciding with MUL of the same channel does not affect that sample; MUL uses the pre-edge value.
- Config clear:
  - cfg_clr zeroes xd[cfg_ch] and yd[cfg_ch].
  - On collision with UPD of the same channel, clear wins for xd and yd. out_data still carries the computed y.
  - cfg_we and cfg_clr in the same cycle: both apply.
- cfg_ch >= NCH: write/clear ignored.
- Reset (asynchronous, immediate, any state):
  - State -> IDLE.
  - All a1, xd, yd, hold, pend, prod_r, out_data, out_ch -> 0.
  - out_valid -> 0; rr_ptr -> NCH-1 (channel 0 wins first); busy -> 0.
  - Any in-flight sample or result is discarded.

Test Plan:
(Bench multiplier model: mult_p = low W bits of the signed product mult_x*mult_a.)
1. Reset:
   - While reset is low: out_valid = 0, in_ready = 0, busy = 0.
   - One cycle after release: in_ready = 4'b1111.
   - Reset asserted while in OUT: out_valid drops without waiting for a clock edge.
2. Channel-0 impulse:
   - Stimulus: cfg a1[0] = 2, then x = 5, 0, 0.
   - Outputs: 0, 5, -10 (0xFFFFFFF6), all with out_ch = 0.
   - out_valid rises 3 edges after each accept.
3. Round-robin:
   - All 4 in_valid asserted at once after reset -> out_ch sequence 0, 1, 2, 3.
   - Channels 0 and 2 held continuously valid -> alternate 0, 2, 0, 2.
4. Backpressure:
   - out_ready low for 5 cycles in OUT -> out_data and out_ch stable, mult operands 0, no new grant.
   - Channel 1 still accepts one sample, then in_ready[1] = 0.
5. Config collision:
   - cfg_we a1[0] = 3 during MUL of channel 0 -> that result uses the old a1; the next channel-0 sample uses 3.
   - cfg_clr ch0 during UPD -> next result = 0 - 0 = 0.
6. Wrap: xd[0] = 0x80000000, prod = 1 (yd = 1, a1 = 1) -> out_data = 0x7FFFFFFF.
